// File: rtl/key_strobe_encoder.sv
// key_strobe_encoder: debounces a 10-line decimal keypad and emits the BCD
// code of each accepted key with a one-cycle strobe. A press must be held
// stable for DEBOUNCE_CYCLES samples, and a full release must be confirmed
// before another key can be accepted.
module key_strobe_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [9:0] keypad,
    output logic [3:0] bcd,
    output logic       data_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam logic [3:0] LAST_COUNT = 4'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        STROBE   = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [9:0] cap;
    logic [3:0] cap_index;
    logic [3:0] cnt_inc;
    logic       keypad_multi;
    logic       keypad_one_hot;

    // Classify the current keypad sample: more than one bit set, or exactly one.
    always_comb begin
        keypad_multi   = (keypad & (keypad - 10'd1)) != '0;
        keypad_one_hot = (keypad != '0) && !keypad_multi;
    end

    // Decimal index of the captured one-hot pattern.
    always_comb begin
        cap_index = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (cap[i]) begin
                cap_index = 4'(i);
            end
        end
    end

    // Saturating increment of the sample counter.
    always_comb begin
        cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    end

    // Press/release debounce state machine with registered outputs.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state      <= IDLE;
            cnt        <= '0;
            cap        <= '0;
            bcd        <= '0;
            data_valid <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (keypad_one_hot) begin
                        cap   <= keypad;
                        cnt   <= 4'd1;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (keypad == cap) begin
                        if (cnt >= LAST_COUNT) begin
                            bcd        <= cap_index;
                            data_valid <= 1'b1;
                            key_held   <= 1'b1;
                            state      <= STROBE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                STROBE: begin
                    data_valid <= 1'b0;
                    cnt        <= '0;
                    state      <= RELEASE;
                end
                RELEASE: begin
                    if (keypad == '0) begin
                        if (cnt >= LAST_COUNT) begin
                            key_held <= 1'b0;
                            cnt      <= '0;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    cnt        <= '0;
                    data_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Multi-key flag tracks every sample regardless of the state machine.
    always_ff @(posedge clock) begin
        if (!clear) begin
            multi_key <= 1'b0;
        end else begin
            multi_key <= keypad_multi;
        end
    end

endmodule

// File: tb/tb_key_strobe_encoder.sv
// Testbench for key_strobe_encoder: two instances (DEBOUNCE_CYCLES 4 and 2)
// share the same stimulus and are compared every cycle against a behavioural
// model, plus directed scenario checks.
module tb_key_strobe_encoder;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic [9:0] keypad = '0;

    logic [3:0] bcd_a, bcd_b;
    logic       dv_a, dv_b, held_a, held_b, multi_a, multi_b;

    int checks   = 0;
    int failures = 0;
    int dv_count [2];

    always #5 clock = ~clock;

    key_strobe_encoder #(.DEBOUNCE_CYCLES(4)) dut_a (
        .clock(clock), .clear(clear), .keypad(keypad),
        .bcd(bcd_a), .data_valid(dv_a), .key_held(held_a), .multi_key(multi_a)
    );

    key_strobe_encoder #(.DEBOUNCE_CYCLES(2)) dut_b (
        .clock(clock), .clear(clear), .keypad(keypad),
        .bcd(bcd_b), .data_valid(dv_b), .key_held(held_b), .multi_key(multi_b)
    );

    // Reference model state, one slot per instance.
    int         m_run   [2];   // stable samples of the candidate key so far
    int         m_zeros [2];   // consecutive zero samples while held
    logic [9:0] m_cand  [2];
    bit         m_held  [2];
    bit         m_fresh [2];   // acceptance happened on the previous edge
    int         m_bcd   [2];
    bit         m_dv    [2];
    bit         m_multi [2];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int popcount(input logic [9:0] v);
        int c = 0;
        for (int i = 0; i < 10; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int key_index(input logic [9:0] v);
        for (int i = 0; i < 10; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step(input int n, input int d, input bit clr, input logic [9:0] s);
        if (!clr) begin
            m_run[n] = 0; m_zeros[n] = 0; m_cand[n] = '0; m_held[n] = 0;
            m_fresh[n] = 0; m_bcd[n] = 0; m_dv[n] = 0; m_multi[n] = 0;
            return;
        end
        m_multi[n] = popcount(s) > 1;
        m_dv[n] = 0;
        if (m_held[n]) begin
            if (m_fresh[n]) begin
                m_fresh[n] = 0;
                m_zeros[n] = 0;
            end else if (s == '0) begin
                m_zeros[n]++;
                if (m_zeros[n] == d) begin
                    m_held[n] = 0;
                    m_zeros[n] = 0;
                end
            end else begin
                m_zeros[n] = 0;
            end
        end else if (m_run[n] == 0) begin
            if (popcount(s) == 1) begin
                m_cand[n] = s;
                m_run[n] = 1;
            end
        end else if (s == m_cand[n]) begin
            m_run[n]++;
            if (m_run[n] == d) begin
                m_bcd[n] = key_index(m_cand[n]);
                m_dv[n] = 1;
                m_held[n] = 1;
                m_fresh[n] = 1;
                m_run[n] = 0;
            end
        end else begin
            m_run[n] = 0;
        end
    endtask

    task automatic tick(input bit clr, input logic [9:0] k);
        @(negedge clock);
        clear = clr;
        keypad = k;
        @(posedge clock);
        model_step(0, 4, clr, k);
        model_step(1, 2, clr, k);
        #1;
        check("a_bcd", int'(bcd_a), m_bcd[0]);
        check("a_dv", int'(dv_a), int'(m_dv[0]));
        check("a_held", int'(held_a), int'(m_held[0]));
        check("a_multi", int'(multi_a), int'(m_multi[0]));
        check("b_bcd", int'(bcd_b), m_bcd[1]);
        check("b_dv", int'(dv_b), int'(m_dv[1]));
        check("b_held", int'(held_b), int'(m_held[1]));
        check("b_multi", int'(multi_b), int'(m_multi[1]));
        dv_count[0] += int'(dv_a);
        dv_count[1] += int'(dv_b);
    endtask

    task automatic ticks(input int n, input bit clr, input logic [9:0] k);
        for (int i = 0; i < n; i++) tick(clr, k);
    endtask

    task automatic do_reset;
        ticks(2, 1'b0, '0);
        check("rst_bcd", int'(bcd_a), 0);
        check("rst_dv", int'(dv_a), 0);
        check("rst_held", int'(held_a), 0);
        check("rst_multi", int'(multi_a), 0);
        dv_count[0] = 0;
        dv_count[1] = 0;
    endtask

    logic [9:0] one = 10'd1;
    logic [9:0] pat;

    initial begin
        for (int n = 0; n < 2; n++) model_step(n, 2, 1'b0, '0);

        // Key 5 press and release
        do_reset;
        ticks(3, 1'b1, 10'b0000100000);
        check("k5_early_dv", int'(dv_a), 0);
        tick(1'b1, 10'b0000100000);
        check("k5_dv", int'(dv_a), 1);
        check("k5_bcd", int'(bcd_a), 5);
        check("k5_held", int'(held_a), 1);
        ticks(5, 1'b1, '0);
        check("k5_release", int'(held_a), 0);
        check("k5_bcd_hold", int'(bcd_a), 5);

        // Bounce on key 3
        do_reset;
        ticks(2, 1'b1, 10'b0000001000);
        tick(1'b1, '0);
        ticks(3, 1'b1, 10'b0000001000);
        check("k3_not_yet", int'(dv_a), 0);
        tick(1'b1, 10'b0000001000);
        check("k3_dv", int'(dv_a), 1);
        check("k3_bcd", int'(bcd_a), 3);
        ticks(3, 1'b1, 10'b0000001000);
        check("k3_one_strobe", dv_count[0], 1);

        // Key 2 during key 7 release is ignored
        do_reset;
        ticks(4, 1'b1, 10'b0010000000);
        check("k7_bcd", int'(bcd_a), 7);
        ticks(10, 1'b1, 10'b0000000100);
        check("k7_still_held", int'(held_a), 1);
        check("k7_bcd_kept", int'(bcd_a), 7);
        check("k7_no_second", dv_count[0], 1);
        ticks(6, 1'b1, '0);
        check("k7_released", int'(held_a), 0);
        ticks(4, 1'b1, 10'b0000000100);
        check("k2_dv", int'(dv_a), 1);
        check("k2_bcd", int'(bcd_a), 2);

        // Two keys together
        do_reset;
        tick(1'b1, 10'b0000000011);
        check("mk_multi", int'(multi_a), 1);
        ticks(9, 1'b1, 10'b0000000011);
        check("mk_no_dv_a", dv_count[0], 0);
        check("mk_no_dv_b", dv_count[1], 0);

        // Clear during debounce of key 9
        do_reset;
        ticks(2, 1'b1, 10'b1000000000);
        tick(1'b0, 10'b1000000000);
        check("clr_bcd", int'(bcd_b), 0);
        check("clr_held", int'(held_b), 0);
        ticks(3, 1'b1, 10'b1000000000);
        check("k9_not_yet", int'(dv_a), 0);
        tick(1'b1, 10'b1000000000);
        check("k9_dv", int'(dv_a), 1);
        check("k9_bcd", int'(bcd_a), 9);

        // Short debounce, key 0 held long
        do_reset;
        tick(1'b1, 10'b0000000001);
        tick(1'b1, 10'b0000000001);
        check("d2_dv", int'(dv_b), 1);
        check("d2_bcd", int'(bcd_b), 0);
        ticks(18, 1'b1, 10'b0000000001);
        check("d2_one_strobe", dv_count[1], 1);

        // Randomized traffic
        do_reset;
        for (int seg = 0; seg < 700; seg++) begin
            int kind = int'($urandom_range(9, 0));
            if (kind < 3) pat = '0;
            else if (kind < 8) pat = one << $urandom_range(9, 0);
            else pat = 10'($urandom);
            if ($urandom_range(59, 0) == 0) begin
                tick(1'b0, pat);
            end else begin
                ticks(int'($urandom_range(7, 1)), 1'b1, pat);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
